// File: rtl/id_stage.sv
// id_stage: instruction decode with register file R0..R14,
// write-through forwarding, condition check and control squash.
// Ports:
//   clk, rst            clock, sync active-high reset
//   pcIn, instruction   PC+4 and fetched word
//   statusIn            {N,Z,C,V} flags
//   hazard              stall request, squashes control
//   wbEn/wbDest/wbValue register write-back port
//   writeBackEn, memReadEn, memWriteEn, b, s, exeCmd
//                       control toward ID/EXE register
//   pc, valRn, valRm    PC pass-through and operands
//   imm, shiftOperand, signedImm24, dest
//                       instruction fields
//   twoSrc, src1, src2  source usage for hazard unit
module id_stage (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] pcIn,
   input  logic [31:0] instruction,
   input  logic [3:0]  statusIn,
   input  logic        hazard,
   input  logic        wbEn,
   input  logic [3:0]  wbDest,
   input  logic [31:0] wbValue,
   output logic        writeBackEn,
   output logic        memReadEn,
   output logic        memWriteEn,
   output logic        b,
   output logic        s,
   output logic [3:0]  exeCmd,
   output logic [31:0] pc,
   output logic [31:0] valRn,
   output logic [31:0] valRm,
   output logic        imm,
   output logic [11:0] shiftOperand,
   output logic [23:0] signedImm24,
   output logic [3:0]  dest,
   output logic        twoSrc,
   output logic [3:0]  src1,
   output logic [3:0]  src2
);

   logic [31:0] regs [0:14];

   logic [3:0] cond;
   logic [1:0] mode;
   logic [3:0] opcode;
   logic       sBit;
   logic [3:0] rn;
   logic [3:0] rd;

   logic       isDp;
   logic       isMem;
   logic       isBr;

   logic       condOk;
   logic       squash;
   logic       wbRaw;
   logic       rdRaw;
   logic       wrRaw;
   logic       brRaw;
   logic       sRaw;

   logic       fN;
   logic       fZ;
   logic       fC;
   logic       fV;

   assign cond   = instruction[31:28];
   assign mode   = instruction[27:26];
   assign opcode = instruction[24:21];
   assign sBit   = instruction[20];
   assign rn     = instruction[19:16];
   assign rd     = instruction[15:12];

   assign isDp  = (mode == 2'b00);
   assign isMem = (mode == 2'b01);
   assign isBr  = (mode == 2'b10);

   assign {fN, fZ, fC, fV} = statusIn;

   // Reset loads each register with its own index.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 15; i++) begin
            regs[i] <= 32'(i);
         end
      end else if (wbEn && wbDest != 4'd15) begin
         regs[wbDest] <= wbValue;
      end
   end

   always_comb begin
      condOk = 1'b0;
      case (cond)
         4'b0000: condOk = fZ;
         4'b0001: condOk = !fZ;
         4'b0010: condOk = fC;
         4'b0011: condOk = !fC;
         4'b0100: condOk = fN;
         4'b0101: condOk = !fN;
         4'b0110: condOk = fV;
         4'b0111: condOk = !fV;
         4'b1000: condOk = fC && !fZ;
         4'b1001: condOk = !fC || fZ;
         4'b1010: condOk = (fN == fV);
         4'b1011: condOk = (fN != fV);
         4'b1100: condOk = !fZ && (fN == fV);
         4'b1101: condOk = fZ || (fN != fV);
         4'b1110: condOk = 1'b1;
         default: condOk = 1'b0;
      endcase
   end

   always_comb begin
      exeCmd = 4'b0000;
      wbRaw  = 1'b0;
      rdRaw  = 1'b0;
      wrRaw  = 1'b0;
      brRaw  = 1'b0;
      sRaw   = 1'b0;
      unique case (1'b1)
         isDp: begin
            case (opcode)
               4'b1101: begin
                  exeCmd = 4'b0001; wbRaw = 1'b1; sRaw = sBit;
               end
               4'b1111: begin
                  exeCmd = 4'b1001; wbRaw = 1'b1; sRaw = sBit;
               end
               4'b0100: begin
                  exeCmd = 4'b0010; wbRaw = 1'b1; sRaw = sBit;
               end
               4'b0101: begin
                  exeCmd = 4'b0011; wbRaw = 1'b1; sRaw = sBit;
               end
               4'b0010: begin
                  exeCmd = 4'b0100; wbRaw = 1'b1; sRaw = sBit;
               end
               4'b0110: begin
                  exeCmd = 4'b0101; wbRaw = 1'b1; sRaw = sBit;
               end
               4'b0000: begin
                  exeCmd = 4'b0110; wbRaw = 1'b1; sRaw = sBit;
               end
               4'b1100: begin
                  exeCmd = 4'b0111; wbRaw = 1'b1; sRaw = sBit;
               end
               4'b0001: begin
                  exeCmd = 4'b1000; wbRaw = 1'b1; sRaw = sBit;
               end
               // CMP and TST only update flags.
               4'b1010: begin
                  exeCmd = 4'b0100; sRaw = sBit;
               end
               4'b1000: begin
                  exeCmd = 4'b0110; sRaw = sBit;
               end
               default: ;
            endcase
         end
         isMem: begin
            exeCmd = 4'b0010;
            if (sBit) begin
               rdRaw = 1'b1;
               wbRaw = 1'b1;
            end else begin
               wrRaw = 1'b1;
            end
         end
         isBr: brRaw = 1'b1;
         default: ;
      endcase
   end

   assign squash = rst || hazard || !condOk;

   assign writeBackEn = wbRaw && !squash;
   assign memReadEn   = rdRaw && !squash;
   assign memWriteEn  = wrRaw && !squash;
   assign b           = brRaw && !squash;
   assign s           = sRaw && !squash;

   // Source info uses the unsquashed store flag so a
   // stall does not change what the hazard unit sees.
   assign src1   = rn;
   assign src2   = wrRaw ? rd : instruction[3:0];
   assign twoSrc = (isDp && !instruction[25]) || wrRaw;

   always_comb begin
      if (src1 == 4'd15) begin
         valRn = pcIn;
      end else if (wbEn && wbDest == src1) begin
         valRn = wbValue;
      end else begin
         valRn = regs[src1];
      end
   end

   always_comb begin
      if (src2 == 4'd15) begin
         valRm = pcIn;
      end else if (wbEn && wbDest == src2) begin
         valRm = wbValue;
      end else begin
         valRm = regs[src2];
      end
   end

   assign pc           = pcIn;
   assign imm          = instruction[25];
   assign shiftOperand = instruction[11:0];
   assign signedImm24  = instruction[23:0];
   assign dest         = rd;

endmodule

// File: tb/tb_id_stage.sv
// tb_id_stage: scoreboard bench for id_stage decode,
// register file, forwarding, squash and reset.
module tb_id_stage;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] pcIn;
   logic [31:0] instruction;
   logic [3:0]  statusIn;
   logic        hazard;
   logic        wbEn;
   logic [3:0]  wbDest;
   logic [31:0] wbValue;
   logic        writeBackEn;
   logic        memReadEn;
   logic        memWriteEn;
   logic        b;
   logic        s;
   logic [3:0]  exeCmd;
   logic [31:0] pc;
   logic [31:0] valRn;
   logic [31:0] valRm;
   logic        imm;
   logic [11:0] shiftOperand;
   logic [23:0] signedImm24;
   logic [3:0]  dest;
   logic        twoSrc;
   logic [3:0]  src1;
   logic [3:0]  src2;

   logic [4:0]  ctrlObs;
   assign ctrlObs = {writeBackEn, memReadEn, memWriteEn, b, s};

   typedef struct {
      logic [4:0]  ctrl;
      logic [3:0]  cmd;
      logic        two;
      logic [3:0]  s1;
      logic [3:0]  s2;
      logic [3:0]  dst;
      logic [31:0] rn;
      logic [31:0] rm;
   } exp_t;

   exp_t        sb[$];
   logic [31:0] mdl [0:14];
   int          checks = 0;
   int          failures = 0;

   id_stage dut (
      .clk(clk), .rst(rst), .pcIn(pcIn),
      .instruction(instruction), .statusIn(statusIn),
      .hazard(hazard), .wbEn(wbEn), .wbDest(wbDest),
      .wbValue(wbValue), .writeBackEn(writeBackEn),
      .memReadEn(memReadEn), .memWriteEn(memWriteEn),
      .b(b), .s(s), .exeCmd(exeCmd), .pc(pc),
      .valRn(valRn), .valRm(valRm), .imm(imm),
      .shiftOperand(shiftOperand),
      .signedImm24(signedImm24), .dest(dest),
      .twoSrc(twoSrc), .src1(src1), .src2(src2)
   );

   always #5 clk = ~clk;

   function automatic logic condModel(
      input logic [3:0] c, input logic [3:0] st);
      logic n, z, cc, v;
      {n, z, cc, v} = st;
      case (c)
         4'd0:  return z;
         4'd1:  return !z;
         4'd2:  return cc;
         4'd3:  return !cc;
         4'd4:  return n;
         4'd5:  return !n;
         4'd6:  return v;
         4'd7:  return !v;
         4'd8:  return cc && !z;
         4'd9:  return !cc || z;
         4'd10: return n == v;
         4'd11: return n != v;
         4'd12: return !z && (n == v);
         4'd13: return z || (n != v);
         4'd14: return 1'b1;
         default: return 1'b0;
      endcase
   endfunction

   // {valid, writes back, cmd}
   function automatic logic [5:0] opModel(input logic [3:0] op);
      case (op)
         4'hD: return 6'b11_0001;
         4'hF: return 6'b11_1001;
         4'h4: return 6'b11_0010;
         4'h5: return 6'b11_0011;
         4'h2: return 6'b11_0100;
         4'h6: return 6'b11_0101;
         4'h0: return 6'b11_0110;
         4'hC: return 6'b11_0111;
         4'h1: return 6'b11_1000;
         4'hA: return 6'b10_0100;
         4'h8: return 6'b10_0110;
         default: return 6'b00_0000;
      endcase
   endfunction

   task automatic test_reset();
      exp_t e;
      @(negedge clk);
      rst = 1'b1; hazard = 1'b0; statusIn = 4'h0;
      pcIn = 32'h100; instruction = 32'hE0821003;
      wbEn = 1'b1; wbDest = 4'd2; wbValue = 32'hAAAA5555;
      e = '{ctrl:5'b0, cmd:4'b0010, two:1'b1, s1:4'd2,
            s2:4'd3, dst:4'd1, rn:32'h0, rm:32'h0};
      sb.push_back(e);
      #1;
      e = sb.pop_front();
      checks++;
      if ({ctrlObs, exeCmd} !== {e.ctrl, e.cmd}) begin
         failures++;
         $display("FAIL rst.ctrl got=%b/%b exp=%b/%b",
                  ctrlObs, exeCmd, e.ctrl, e.cmd);
      end
      @(posedge clk);
      for (int i = 0; i < 15; i++) mdl[i] = 32'(i);
      #1;
      rst = 1'b0; wbEn = 1'b0;
      for (int i = 0; i < 15; i++) begin
         instruction = 32'hE0800000 | (32'(i) << 16)
                       | 32'(14 - i);
         e = '{ctrl:5'b10000, cmd:4'b0010, two:1'b1,
               s1:4'(i), s2:4'(14 - i), dst:4'd0,
               rn:mdl[i], rm:mdl[14 - i]};
         sb.push_back(e);
         #1;
         e = sb.pop_front();
         checks++;
         if ({valRn, valRm} !== {e.rn, e.rm}) begin
            failures++;
            $display("FAIL rst.R%0d got=%h/%h exp=%h/%h",
                     i, valRn, valRm, e.rn, e.rm);
         end
      end
   endtask

   task automatic test_add();
      exp_t e;
      @(negedge clk);
      instruction = 32'hE0821003; statusIn = 4'h0;
      pcIn = 32'h0000_0404;
      e = '{ctrl:5'b10000, cmd:4'b0010, two:1'b1, s1:4'd2,
            s2:4'd3, dst:4'd1, rn:mdl[2], rm:mdl[3]};
      sb.push_back(e);
      #1;
      e = sb.pop_front();
      checks++;
      if ({ctrlObs, exeCmd} !== {e.ctrl, e.cmd}) begin
         failures++;
         $display("FAIL add.ctrl got=%b/%b exp=%b/%b",
                  ctrlObs, exeCmd, e.ctrl, e.cmd);
      end
      checks++;
      if ({valRn, valRm} !== {e.rn, e.rm}) begin
         failures++;
         $display("FAIL add.vals got=%h/%h exp=%h/%h",
                  valRn, valRm, e.rn, e.rm);
      end
      checks++;
      if ({twoSrc, src1, src2, dest} !==
          {e.two, e.s1, e.s2, e.dst}) begin
         failures++;
         $display("FAIL add.src got=%b/%h/%h/%h exp=%b/%h/%h/%h",
                  twoSrc, src1, src2, dest,
                  e.two, e.s1, e.s2, e.dst);
      end
      checks++;
      if ({pc, imm, shiftOperand, signedImm24} !==
          {32'h0000_0404, 1'b0, 12'h003, 24'h821003}) begin
         failures++;
         $display("FAIL add.fields got=%h/%b/%h/%h",
                  pc, imm, shiftOperand, signedImm24);
      end
   endtask

   task automatic test_forward();
      exp_t e;
      @(negedge clk);
      instruction = 32'hE0841003;
      wbEn = 1'b1; wbDest = 4'd4; wbValue = 32'hDEADBEEF;
      e = '{ctrl:5'b10000, cmd:4'b0010, two:1'b1, s1:4'd4,
            s2:4'd3, dst:4'd1, rn:32'hDEADBEEF, rm:mdl[3]};
      sb.push_back(e);
      #1;
      e = sb.pop_front();
      checks++;
      if ({valRn, valRm} !== {e.rn, e.rm}) begin
         failures++;
         $display("FAIL fwd.same got=%h/%h exp=%h/%h",
                  valRn, valRm, e.rn, e.rm);
      end
      @(posedge clk);
      mdl[4] = 32'hDEADBEEF;
      #1;
      wbEn = 1'b0;
      e.rn = mdl[4];
      sb.push_back(e);
      #1;
      e = sb.pop_front();
      checks++;
      if (valRn !== e.rn) begin
         failures++;
         $display("FAIL fwd.held got=%h exp=%h", valRn, e.rn);
      end
   endtask

   task automatic test_cond();
      exp_t e;
      for (int c = 0; c < 16; c++) begin
         for (int st = 0; st < 16; st++) begin
            @(negedge clk);
            instruction = {4'(c), 28'h0821003};
            statusIn = 4'(st);
            e = '{ctrl:5'b0, cmd:4'b0010, two:1'b1, s1:4'd2,
                  s2:4'd3, dst:4'd1, rn:32'h0, rm:32'h0};
            if (condModel(4'(c), 4'(st))) e.ctrl = 5'b10000;
            sb.push_back(e);
            #1;
            e = sb.pop_front();
            checks++;
            if ({ctrlObs, exeCmd} !== {e.ctrl, e.cmd}) begin
               failures++;
               $display("FAIL cond c=%h st=%b got=%b/%b exp=%b/%b",
                        c, st, ctrlObs, exeCmd, e.ctrl, e.cmd);
            end
         end
      end
      statusIn = 4'h0;
   endtask

   task automatic test_opcodes();
      exp_t e;
      logic [5:0] m;
      for (int sv = 0; sv < 2; sv++) begin
         for (int op = 0; op < 16; op++) begin
            @(negedge clk);
            instruction = {4'hE, 2'b00, 1'b1, 4'(op), 1'(sv),
                           4'h5, 4'h6, 12'h0AB};
            m = opModel(4'(op));
            e = '{ctrl:{m[4], 3'b000, m[5] & 1'(sv)},
                  cmd:m[3:0], two:1'b0, s1:4'd5, s2:4'hB,
                  dst:4'd6, rn:32'h0, rm:32'h0};
            sb.push_back(e);
            #1;
            e = sb.pop_front();
            checks++;
            if ({ctrlObs, exeCmd, twoSrc} !==
                {e.ctrl, e.cmd, e.two}) begin
               failures++;
               $display("FAIL op=%h S=%0d got=%b/%b/%b exp=%b/%b/%b",
                        op, sv, ctrlObs, exeCmd, twoSrc,
                        e.ctrl, e.cmd, e.two);
            end
         end
      end
   endtask

   task automatic test_mem();
      exp_t e;
      @(negedge clk);
      instruction = 32'hE5821004;
      e = '{ctrl:5'b00100, cmd:4'b0010, two:1'b1, s1:4'd2,
            s2:4'd1, dst:4'd1, rn:mdl[2], rm:mdl[1]};
      sb.push_back(e);
      #1;
      e = sb.pop_front();
      checks++;
      if ({ctrlObs, exeCmd, twoSrc, src2, valRm} !==
          {e.ctrl, e.cmd, e.two, e.s2, e.rm}) begin
         failures++;
         $display("FAIL str got=%b/%b/%b/%h/%h exp=%b/%b/%b/%h/%h",
                  ctrlObs, exeCmd, twoSrc, src2, valRm,
                  e.ctrl, e.cmd, e.two, e.s2, e.rm);
      end
      @(negedge clk);
      instruction = 32'hE5921004;
      e = '{ctrl:5'b11000, cmd:4'b0010, two:1'b0, s1:4'd2,
            s2:4'd4, dst:4'd1, rn:mdl[2], rm:mdl[4]};
      sb.push_back(e);
      #1;
      e = sb.pop_front();
      checks++;
      if ({ctrlObs, exeCmd, twoSrc, src2} !==
          {e.ctrl, e.cmd, e.two, e.s2}) begin
         failures++;
         $display("FAIL ldr got=%b/%b/%b/%h exp=%b/%b/%b/%h",
                  ctrlObs, exeCmd, twoSrc, src2,
                  e.ctrl, e.cmd, e.two, e.s2);
      end
   endtask

   task automatic test_branch();
      exp_t e;
      @(negedge clk);
      instruction = 32'hEA000010;
      e = '{ctrl:5'b00010, cmd:4'b0000, two:1'b0, s1:4'd0,
            s2:4'd0, dst:4'd0, rn:32'h0, rm:32'h0};
      sb.push_back(e);
      #1;
      e = sb.pop_front();
      checks++;
      if ({ctrlObs, exeCmd, twoSrc, signedImm24} !==
          {e.ctrl, e.cmd, e.two, 24'h000010}) begin
         failures++;
         $display("FAIL br got=%b/%b/%b/%h exp=%b/%b/%b/000010",
                  ctrlObs, exeCmd, twoSrc, signedImm24,
                  e.ctrl, e.cmd, e.two);
      end
      @(negedge clk);
      instruction = 32'hEC000000;
      e.ctrl = 5'b00000;
      sb.push_back(e);
      #1;
      e = sb.pop_front();
      checks++;
      if ({ctrlObs, exeCmd, twoSrc} !==
          {e.ctrl, e.cmd, e.two}) begin
         failures++;
         $display("FAIL mode11 got=%b/%b/%b exp=%b/%b/%b",
                  ctrlObs, exeCmd, twoSrc, e.ctrl, e.cmd, e.two);
      end
   endtask

   task automatic test_hazard();
      exp_t e;
      @(negedge clk);
      hazard = 1'b1;
      instruction = 32'hE0821003;
      e = '{ctrl:5'b0, cmd:4'b0010, two:1'b1, s1:4'd2,
            s2:4'd3, dst:4'd1, rn:mdl[2], rm:mdl[3]};
      sb.push_back(e);
      #1;
      e = sb.pop_front();
      checks++;
      if ({ctrlObs, exeCmd, twoSrc, src1, src2} !==
          {e.ctrl, e.cmd, e.two, e.s1, e.s2}) begin
         failures++;
         $display("FAIL hz.add got=%b/%b/%b/%h/%h exp=%b/%b/%b/%h/%h",
                  ctrlObs, exeCmd, twoSrc, src1, src2,
                  e.ctrl, e.cmd, e.two, e.s1, e.s2);
      end
      @(negedge clk);
      instruction = 32'hE5821004;
      e = '{ctrl:5'b0, cmd:4'b0010, two:1'b1, s1:4'd2,
            s2:4'd1, dst:4'd1, rn:mdl[2], rm:mdl[1]};
      sb.push_back(e);
      #1;
      e = sb.pop_front();
      checks++;
      if ({ctrlObs, twoSrc, src2} !== {e.ctrl, e.two, e.s2}) begin
         failures++;
         $display("FAIL hz.str got=%b/%b/%h exp=%b/%b/%h",
                  ctrlObs, twoSrc, src2, e.ctrl, e.two, e.s2);
      end
      @(negedge clk);
      hazard = 1'b0;
      pcIn = 32'h0000_1234;
      instruction = 32'hE08F100F;
      wbEn = 1'b1; wbDest = 4'd15; wbValue = 32'hFFFF0000;
      e = '{ctrl:5'b10000, cmd:4'b0010, two:1'b1, s1:4'hF,
            s2:4'hF, dst:4'd1, rn:32'h1234, rm:32'h1234};
      sb.push_back(e);
      #1;
      e = sb.pop_front();
      checks++;
      if ({valRn, valRm} !== {e.rn, e.rm}) begin
         failures++;
         $display("FAIL r15.same got=%h/%h exp=%h/%h",
                  valRn, valRm, e.rn, e.rm);
      end
      @(posedge clk);
      #1;
      wbEn = 1'b0;
      pcIn = 32'h0000_5678;
      instruction = 32'hE08F100E;
      e.rn = 32'h5678; e.rm = mdl[14];
      sb.push_back(e);
      #1;
      e = sb.pop_front();
      checks++;
      if ({valRn, valRm} !== {e.rn, e.rm}) begin
         failures++;
         $display("FAIL r15.after got=%h/%h exp=%h/%h",
                  valRn, valRm, e.rn, e.rm);
      end
   endtask

   task automatic test_back_to_back();
      exp_t e;
      logic [31:0] v;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         v = $urandom;
         wbEn = 1'b1; wbDest = 4'(5 + k); wbValue = v;
         instruction = 32'hE0800000 | (32'(4 + k) << 16)
                       | 32'(5 + k);
         e = '{ctrl:5'b10000, cmd:4'b0010, two:1'b1,
               s1:4'(4 + k), s2:4'(5 + k), dst:4'd0,
               rn:mdl[4 + k], rm:v};
         sb.push_back(e);
         #1;
         e = sb.pop_front();
         checks++;
         if ({valRn, valRm} !== {e.rn, e.rm}) begin
            failures++;
            $display("FAIL b2b.k%0d got=%h/%h exp=%h/%h",
                     k, valRn, valRm, e.rn, e.rm);
         end
         @(posedge clk);
         mdl[5 + k] = v;
      end
      #1;
      wbEn = 1'b0;
   endtask

   task automatic test_reset_mid();
      exp_t e;
      @(negedge clk);
      rst = 1'b1;
      wbEn = 1'b1; wbDest = 4'd7; wbValue = 32'h12345678;
      @(posedge clk);
      for (int i = 0; i < 15; i++) mdl[i] = 32'(i);
      #1;
      rst = 1'b0; wbEn = 1'b0;
      instruction = 32'hE0871005;
      e = '{ctrl:5'b10000, cmd:4'b0010, two:1'b1, s1:4'd7,
            s2:4'd5, dst:4'd1, rn:mdl[7], rm:mdl[5]};
      sb.push_back(e);
      #1;
      e = sb.pop_front();
      checks++;
      if ({valRn, valRm, ctrlObs} !==
          {e.rn, e.rm, e.ctrl}) begin
         failures++;
         $display("FAIL rstmid got=%h/%h/%b exp=%h/%h/%b",
                  valRn, valRm, ctrlObs, e.rn, e.rm, e.ctrl);
      end
      @(negedge clk);
      wbEn = 1'b1; wbDest = 4'd2; wbValue = 32'hCAFEF00D;
      @(posedge clk);
      mdl[2] = 32'hCAFEF00D;
      #1;
      wbEn = 1'b0;
      instruction = 32'hE0821003;
      e.rn = mdl[2]; e.rm = mdl[3];
      sb.push_back(e);
      #1;
      e = sb.pop_front();
      checks++;
      if ({valRn, valRm} !== {e.rn, e.rm}) begin
         failures++;
         $display("FAIL rstrel got=%h/%h exp=%h/%h",
                  valRn, valRm, e.rn, e.rm);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "timeout");
   end

   initial begin
      rst = 1'b1; hazard = 1'b0; statusIn = 4'h0;
      pcIn = 32'h0; instruction = 32'h0;
      wbEn = 1'b0; wbDest = 4'h0; wbValue = 32'h0;
      test_reset();
      test_add();
      test_forward();
      test_cond();
      test_opcodes();
      test_mem();
      test_branch();
      test_hazard();
      test_back_to_back();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d",
               checks, failures);
      $finish;
   end

endmodule
